fifo_rd_drainer: RTL and testbench

Read-side consumer for async_fifo. It sits in the rd_clk domain on the FIFO read port (rd_en, empty, almost_empty, rd_ack, rd_err, dout). It pops words whenever data and downstream space exist, absorbs the FIFO's one-cycle read latency in an internal skid buffer, and presents the words as a valid/ready stream. It also keeps a pop counter and sticky protocol-error flags for the testbench and for system status.

---
 rtl/fifo_rd_drainer.sv | 142 ++++++++++++++
 tb/tb_fifo_rd_drainer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drainer.sv
// fifo_rd_drainer: read-side consumer for async_fifo. Pops words into a small
// skid buffer and presents them as a valid/ready stream with pop/error status.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no read issued; waits for enable, data and buffer space
// FETCH | rd_en asserted this cycle
// GAP   | one forced idle cycle after a read taken with almost_empty=1
module fifo_rd_drainer #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  empty,
    input  logic                  almost_empty,
    input  logic                  rd_ack,
    input  logic                  rd_err,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  pop_count,
    output logic                  ack_err,
    output logic                  rd_err_seen,
    input  logic                  err_clr
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW = AW + 1;
    localparam int SW = AW + 2;
    localparam logic [SW-1:0] DEPTH_S = SW'(BUF_DEPTH);
    localparam logic [SW-1:0] ONE_S   = SW'(1);
    localparam logic [SW-1:0] TWO_S   = SW'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  inflight;
    logic                  first_cyc;
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [OW-1:0]         occ;
    logic [SW-1:0]         resv;
    logic                  space_idle;
    logic                  space_more;
    logic                  avail;
    logic                  cap;
    logic                  pop;
    logic                  ack_err_set;

    // Slots already spoken for: buffered words plus the read whose ack is due now.
    assign resv       = SW'(occ) + SW'(inflight);
    assign space_idle = (resv + ONE_S) <= DEPTH_S;
    assign space_more = (resv + TWO_S) <= DEPTH_S;
    assign avail      = enable && !empty;

    // An ack landing on the first cycle after reset belongs to a discarded read.
    assign cap         = rd_ack && inflight && !rd_err && !first_cyc;
    assign ack_err_set = (inflight && !rd_ack) || (!inflight && rd_ack && !first_cyc);

    assign m_valid = (occ != '0);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;
    assign pop     = m_valid && m_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (avail && space_idle) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (avail && !almost_empty && space_more) begin
                    state_nxt = FETCH;
                end else if (almost_empty) begin
                    state_nxt = GAP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge rd_clk or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            rd_en       <= 1'b0;
            inflight    <= 1'b0;
            first_cyc   <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            pop_count   <= '0;
            ack_err     <= 1'b0;
            rd_err_seen <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_en     <= (state_nxt == FETCH);
            inflight  <= rd_en;
            first_cyc <= 1'b0;
            if (cap) begin
                wr_ptr    <= wr_ptr + AW'(1);
                pop_count <= pop_count + CNT_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({cap, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
            ack_err     <= ack_err_set | (ack_err & ~err_clr);
            rd_err_seen <= rd_err | (rd_err_seen & ~err_clr);
        end
    end

    // Storage needs no reset: m_data is gated by occupancy.
    always_ff @(posedge rd_clk) begin
        if (cap) begin
            mem[wr_ptr] <= dout;
        end
    end

endmodule

// File: tb/tb_fifo_rd_drainer.sv
// tb_fifo_rd_drainer: drives fifo_rd_drainer from a behavioural FIFO source and
// checks the output stream against the words the FIFO actually handed over.
module tb_fifo_rd_drainer;

    localparam int DW = 8;
    localparam int BD = 4;
    localparam int CW = 16;

    logic          rd_clk = 1'b0;
    logic          clear;
    logic          enable;
    logic          empty = 1'b1;
    logic          almost_empty = 1'b0;
    logic          rd_ack = 1'b0;
    logic          rd_err = 1'b0;
    logic [DW-1:0] dout = '0;
    logic          rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] pop_count;
    logic          ack_err;
    logic          rd_err_seen;
    logic          err_clr;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_drainer #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_WIDTH(CW)) dut (
        .rd_clk      (rd_clk),
        .clear       (clear),
        .enable      (enable),
        .empty       (empty),
        .almost_empty(almost_empty),
        .rd_ack      (rd_ack),
        .rd_err      (rd_err),
        .dout        (dout),
        .rd_en       (rd_en),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .pop_count   (pop_count),
        .ack_err     (ack_err),
        .rd_err_seen (rd_err_seen),
        .err_clr     (err_clr)
    );

    // FIFO contents (written by the stimulus) and words handed over with a clean ack
    logic [7:0] fifo_mem [0:1023];
    logic [7:0] exp_mem  [0:1023];
    logic [7:0] got_mem  [0:1023];
    int fwr = 0, frd = 0, exp_wr = 0, exp_rd = 0, got_n = 0, rd_pulses = 0;
    int spur_req = 0, spur_done = 0, drop_req = 0, drop_done = 0, err_req = 0, err_done = 0;
    int checks = 0, failures = 0;
    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = '0;

    logic model_pop;
    int   left;
    assign model_pop = rd_en && (fwr != frd);
    assign left      = fwr - frd - (model_pop ? 1 : 0);

    always @(posedge rd_clk) begin
        rd_ack <= 1'b0;
        rd_err <= 1'b0;
        if (model_pop) begin
            dout <= fifo_mem[frd];
            frd  <= frd + 1;
            if (drop_req != drop_done) begin
                drop_done <= drop_done + 1;
            end else if (err_req != err_done) begin
                err_done <= err_done + 1;
                rd_ack   <= 1'b1;
                rd_err   <= 1'b1;
            end else begin
                rd_ack          <= 1'b1;
                exp_mem[exp_wr] <= fifo_mem[frd];
                exp_wr          <= exp_wr + 1;
            end
        end else if (rd_en) begin
            rd_err <= 1'b1;
        end
        if (spur_req != spur_done) begin
            spur_done <= spur_done + 1;
            rd_ack    <= 1'b1;
            dout      <= 8'hEE;
        end
        empty        <= (left == 0);
        almost_empty <= (left == 1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_mem[fwr] = w;
        fwr++;
    endtask

    // One clock: observe mid-cycle at negedge, then return just after the posedge.
    task automatic tick();
        @(negedge rd_clk);
        if (rd_en) begin
            rd_pulses++;
            chk("rd_en_while_empty", empty, 0);
        end
        if (prev_v && !prev_r && !clear) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_d);
        end
        if (m_valid && m_ready && !clear) begin
            got_mem[got_n] = m_data;
            got_n++;
            if (exp_rd < exp_wr) begin
                chk("out_order", m_data, exp_mem[exp_rd]);
                exp_rd++;
            end else begin
                chk("out_unexpected", m_valid, 0);
            end
        end
        if (clear) exp_rd = exp_wr;
        prev_v = m_valid;
        prev_r = m_ready;
        prev_d = m_data;
        @(posedge rd_clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (i < budget && !(fwr == frd && exp_rd == exp_wr && !m_valid && !rd_en)) begin
            tick();
            i++;
        end
        chk("drain_in_time", (i < budget), 1);
    endtask

    initial begin
        logic [CW-1:0] base_pop;
        logic [7:0]    w;
        int            base_got, base_rdp, n_left, k, pushed;

        clear = 1'b1; enable = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < 3; i++) push_word(8'($urandom));
        tick(); tick();
        spur_req = 1;
        tick();
        chk("rst_rd_en", rd_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_pop_count", pop_count, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_rd_err_seen", rd_err_seen, 0);

        clear = 1'b0; enable = 1'b1; m_ready = 1'b1;
        #1;
        chk("rel_rd_en_low", rd_en, 0);
        tick();
        chk("rel_first_rd_en", rd_en, 1);
        chk("rel_stray_ack_cnt", pop_count, 0);
        chk("rel_stray_ack_err", ack_err, 0);
        wait_drain(100);
        chk("rst_drain_got", got_n, 3);
        chk("rst_drain_pop", pop_count, 3);

        base_pop = pop_count; base_got = got_n;
        for (int i = 0; i < 16; i++) push_word(8'(16 + i));
        wait_drain(200);
        chk("stream_count", got_n - base_got, 16);
        for (int i = 0; i < 16; i++) chk("stream_data", got_mem[base_got + i], 16 + i);
        chk("stream_pop", pop_count - base_pop, 16);
        chk("stream_rd_err_seen", rd_err_seen, 0);

        m_ready = 1'b0; base_got = got_n; base_rdp = rd_pulses;
        for (int i = 0; i < 10; i++) push_word(8'(16 + i));
        repeat (20) tick();
        chk("bp_rd_en_pulses", rd_pulses - base_rdp, 4);
        chk("bp_valid", m_valid, 1);
        chk("bp_data", m_data, 8'h10);
        chk("bp_fifo_left", fwr - frd, 6);
        m_ready = 1'b1;
        wait_drain(200);
        chk("bp_count", got_n - base_got, 10);
        for (int i = 0; i < 10; i++) chk("bp_data_order", got_mem[base_got + i], 16 + i);

        base_rdp = rd_pulses; w = 8'($urandom);
        push_word(w);
        k = 0;
        while (!rd_en && k < 20) begin tick(); k++; end
        chk("lw_rd_en_seen", rd_en, 1);
        chk("lw_lat0_valid", m_valid, 0);
        tick();
        chk("lw_lat1_valid", m_valid, 0);
        tick();
        chk("lw_lat2_valid", m_valid, 1);
        chk("lw_data", m_data, w);
        repeat (6) tick();
        chk("lw_rd_en_pulses", rd_pulses - base_rdp, 1);
        chk("lw_rd_err_seen", rd_err_seen, 0);

        base_pop = pop_count;
        drop_req = drop_req + 1;
        push_word(8'($urandom));
        k = 0;
        while (!ack_err && k < 30) begin tick(); k++; end
        chk("err_ack_err", ack_err, 1);
        chk("err_drop_pop", pop_count, base_pop);
        chk("err_drop_rd_err_seen", rd_err_seen, 0);
        err_req = err_req + 1;
        push_word(8'($urandom));
        k = 0;
        while (!rd_err_seen && k < 30) begin tick(); k++; end
        chk("err_rd_err_seen", rd_err_seen, 1);
        chk("err_rd_err_pop", pop_count, base_pop);
        repeat (4) tick();
        chk("err_no_output", m_valid, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_ack_err", ack_err, 0);
        chk("clr_rd_err_seen", rd_err_seen, 0);

        err_clr = 1'b1;
        err_req = err_req + 1;
        push_word(8'($urandom));
        k = 0;
        while (!rd_err_seen && k < 30) begin tick(); k++; end
        chk("set_beats_clr", rd_err_seen, 1);
        tick();
        chk("clr_after_set", rd_err_seen, 0);
        err_clr = 1'b0;

        base_pop = pop_count; base_got = got_n; pushed = 0;
        for (int c = 0; c < 150; c++) begin
            if (pushed < 40 && $urandom_range(0, 2) != 0) begin
                push_word(8'($urandom));
                pushed++;
            end
            m_ready = ($urandom_range(0, 3) != 0);
            enable  = ($urandom_range(0, 7) != 0);
            tick();
        end
        enable = 1'b1; m_ready = 1'b1;
        wait_drain(300);
        chk("rand_count", got_n - base_got, pushed);
        chk("rand_pop", pop_count - base_pop, pushed);
        chk("rand_ack_err", ack_err, 0);

        for (int i = 0; i < 12; i++) push_word(8'($urandom));
        repeat (6) tick();
        chk("mid_valid_before", m_valid, 1);
        clear = 1'b1;
        #1;
        chk("mid_valid_drop", m_valid, 0);
        chk("mid_rd_en_drop", rd_en, 0);
        enable = 1'b0;
        tick(); tick();
        clear = 1'b0;
        repeat (3) tick();
        chk("mid_pop_zero", pop_count, 0);
        chk("mid_valid_idle", m_valid, 0);
        n_left = fwr - frd; base_got = got_n;
        enable = 1'b1;
        wait_drain(200);
        chk("mid_rest_pop", pop_count, n_left);
        chk("mid_rest_count", got_n - base_got, n_left);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
